// File: rtl/audio_sample_sequencer.sv
// -----------------------------------------------------------------------------
// audio_sample_sequencer
//
// Playback engine for the audio path. It steps through a ROM region
// [start_addr..end_addr] once per audio frame, either one-shot or looping,
// under a level-sensitive play/stop control. It hands scaled left/right
// samples and a valid flag to the serializer.
//
// Build option:
//   AUDIO_SEQ_FADE_EN - when defined, adds an 8-frame fade-in on start and an
//                       8-frame fade-out on stop. When undefined, starts and
//                       stops are abrupt.
//
// Ports:
//   DAC_LR_CLK    in   frame clock; all logic runs on its rising edge
//   reset         in   synchronous, active-low reset
//   play          in   level: 1 = run / keep running, 0 = stop
//   loop_en       in   1 = wrap at end_addr, 0 = one-shot (sampled at the end compare)
//   start_addr    in   first ROM address, latched at start
//   end_addr      in   last ROM address (inclusive), latched at start
//   vol_shift     in   arithmetic right-shift attenuation, sampled every frame
//   rom_addr      out  ROM address
//   rom_rden      out  ROM read enable
//   rom_q         in   ROM word, valid one frame after its address/rden
//   sample_l/_r   out  left/right samples
//   sample_valid  out  samples carry live playback data
//   busy          out  engine is not idle
//   done          out  one-frame pulse when a one-shot pass completes
// -----------------------------------------------------------------------------
module audio_sample_sequencer #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int CHANNELS = 1,
    parameter int VOL_W    = 4
) (
    input  logic                         DAC_LR_CLK,
    input  logic                         reset,
    input  logic                         play,
    input  logic                         loop_en,
    input  logic [ADDR_W-1:0]            start_addr,
    input  logic [ADDR_W-1:0]            end_addr,
    input  logic [VOL_W-1:0]             vol_shift,
    output logic [ADDR_W-1:0]            rom_addr,
    output logic                         rom_rden,
    input  logic [CHANNELS*DATA_W-1:0]   rom_q,
    output logic [DATA_W-1:0]            sample_l,
    output logic [DATA_W-1:0]            sample_r,
    output logic                         sample_valid,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   start_lat_q, start_lat_d;
    logic [ADDR_W-1:0]   end_lat_q, end_lat_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                rom_rden_q, rom_rden_d;
    // Set after the first PLAY frame: from then on rom_q holds real data.
    logic                primed_q, primed_d;
    logic [DATA_W-1:0]   sample_l_q, sample_l_d;
    logic [DATA_W-1:0]   sample_r_q, sample_r_d;
    logic                sample_valid_q, sample_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   raw_l_s;
    logic [DATA_W-1:0]   raw_r_s;
    logic [31:0]         shift_s;
    logic                stop_s;

    // Signed arithmetic right shift. Shifts of DATA_W or more give exactly
    // zero, so negative samples do not settle at -1.
    function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] x,
                                                input logic [31:0]       sh);
        logic [DATA_W-1:0] res;
        if (sh >= 32'(DATA_W)) begin
            res = {DATA_W{1'b0}};
        end else begin
            res = DATA_W'($signed(x) >>> sh);
        end
        return res;
    endfunction

    generate
        if (CHANNELS == 2) begin : g_stereo
            assign raw_l_s = rom_q[2*DATA_W-1:DATA_W];
            assign raw_r_s = rom_q[DATA_W-1:0];
        end else begin : g_mono
            assign raw_l_s = rom_q[DATA_W-1:0];
            assign raw_r_s = rom_q[DATA_W-1:0];
        end
    endgenerate

`ifdef AUDIO_SEQ_FADE_EN
    // Fade stage: this many extra bits of attenuation are added on top of vol_shift.
    logic [3:0] fade_q, fade_d;
    assign shift_s = 32'(vol_shift) + 32'(fade_q);
    // A stop request takes effect only after the fade-out has fully completed.
    assign stop_s  = !play && (fade_q == 4'd8);
`else
    assign shift_s = 32'(vol_shift);
    assign stop_s  = !play;
`endif

    // Next-state and next-output computation for the playback FSM.
    always_comb begin
        state_d        = state_q;
        start_lat_d    = start_lat_q;
        end_lat_d      = end_lat_q;
        rom_addr_d     = rom_addr_q;
        rom_rden_d     = rom_rden_q;
        primed_d       = primed_q;
        busy_d         = busy_q;
        sample_l_d     = {DATA_W{1'b0}};
        sample_r_d     = {DATA_W{1'b0}};
        sample_valid_d = 1'b0;
        done_d         = 1'b0;
`ifdef AUDIO_SEQ_FADE_EN
        fade_d         = fade_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (play) begin
                    start_lat_d = start_addr;
                    // An inverted range collapses to a single address.
                    end_lat_d   = (end_addr < start_addr) ? start_addr : end_addr;
                    rom_addr_d  = start_addr;
                    rom_rden_d  = 1'b1;
                    busy_d      = 1'b1;
                    primed_d    = 1'b0;
                    state_d     = ST_PLAY;
`ifdef AUDIO_SEQ_FADE_EN
                    fade_d      = 4'd8;
`endif
                end else begin
                    rom_rden_d  = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            ST_PLAY: begin
                if (stop_s) begin
                    rom_rden_d = 1'b0;
                    busy_d     = 1'b0;
                    primed_d   = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    primed_d       = 1'b1;
                    sample_valid_d = primed_q;
                    if (primed_q) begin
                        sample_l_d = scale(raw_l_s, shift_s);
                        sample_r_d = scale(raw_r_s, shift_s);
                    end else begin
                        sample_l_d = {DATA_W{1'b0}};
                        sample_r_d = {DATA_W{1'b0}};
                    end
`ifdef AUDIO_SEQ_FADE_EN
                    if (!play) begin
                        fade_d = fade_q + 4'd1;
                    end else if (primed_q && (fade_q != 4'd0)) begin
                        fade_d = fade_q - 4'd1;
                    end else begin
                        fade_d = fade_q;
                    end
`endif
                    if (rom_addr_q != end_lat_q) begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1'b1);
                    end else if (loop_en) begin
                        // Seamless wrap: the next frame reads start with no gap.
                        rom_addr_d = start_lat_q;
                    end else begin
                        rom_rden_d = 1'b0;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The ROM word of the final address arrives now.
                sample_valid_d = 1'b1;
                sample_l_d     = scale(raw_l_s, shift_s);
                sample_r_d     = scale(raw_r_s, shift_s);
                done_d         = 1'b1;
                primed_d       = 1'b0;
                state_d        = ST_IDLE;
            end
            default: begin
                rom_rden_d = 1'b0;
                busy_d     = 1'b0;
                primed_d   = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset is synchronous and active-low.
    always_ff @(posedge DAC_LR_CLK) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            start_lat_q    <= {ADDR_W{1'b0}};
            end_lat_q      <= {ADDR_W{1'b0}};
            rom_addr_q     <= {ADDR_W{1'b0}};
            rom_rden_q     <= 1'b0;
            primed_q       <= 1'b0;
            sample_l_q     <= {DATA_W{1'b0}};
            sample_r_q     <= {DATA_W{1'b0}};
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef AUDIO_SEQ_FADE_EN
            fade_q         <= 4'd0;
`endif
        end else begin
            state_q        <= state_d;
            start_lat_q    <= start_lat_d;
            end_lat_q      <= end_lat_d;
            rom_addr_q     <= rom_addr_d;
            rom_rden_q     <= rom_rden_d;
            primed_q       <= primed_d;
            sample_l_q     <= sample_l_d;
            sample_r_q     <= sample_r_d;
            sample_valid_q <= sample_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
`ifdef AUDIO_SEQ_FADE_EN
            fade_q         <= fade_d;
`endif
        end
    end

    assign rom_addr     = rom_addr_q;
    assign rom_rden     = rom_rden_q;
    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = sample_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// -----------------------------------------------------------------------------
// tb_audio_sample_sequencer
//
// Drives two sequencers from shared controls: a mono build (defaults) and a
// stereo build with a 5-bit volume input, so that shifts of 16 and above can
// be reached. Each build has a synchronous ROM model. Every play session is
// described by (start, end, loop, abort frame, reset frame). Expected outputs
// after each frame edge are derived from those parameters arithmetically:
// address = start + k mod length, sample = floor(word / 2^shift), and so on.
// -----------------------------------------------------------------------------
module tb_audio_sample_sequencer;

    localparam int AW = 18;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              play;
    logic              loop_en;
    logic [AW-1:0]     start_addr;
    logic [AW-1:0]     end_addr;
    logic [4:0]        vol;

    logic [AW-1:0]     m_addr, s_addr;
    logic              m_rden, s_rden;
    logic [DW-1:0]     m_q;
    logic [2*DW-1:0]   s_q;
    logic [DW-1:0]     m_l, m_r, s_l, s_r;
    logic              m_v, s_v, m_busy, s_busy, m_done, s_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_sample_sequencer u_dut_mono (
        .DAC_LR_CLK   (clk),
        .reset        (reset),
        .play         (play),
        .loop_en      (loop_en),
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .vol_shift    (vol[3:0]),
        .rom_addr     (m_addr),
        .rom_rden     (m_rden),
        .rom_q        (m_q),
        .sample_l     (m_l),
        .sample_r     (m_r),
        .sample_valid (m_v),
        .busy         (m_busy),
        .done         (m_done)
    );

    audio_sample_sequencer #(.CHANNELS(2), .VOL_W(5)) u_dut_st (
        .DAC_LR_CLK   (clk),
        .reset        (reset),
        .play         (play),
        .loop_en      (loop_en),
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .vol_shift    (vol),
        .rom_addr     (s_addr),
        .rom_rden     (s_rden),
        .rom_q        (s_q),
        .sample_l     (s_l),
        .sample_r     (s_r),
        .sample_valid (s_v),
        .busy         (s_busy),
        .done         (s_done)
    );

    // ROM contents: a few fixed words for directed cases, hashes elsewhere.
    function automatic logic [DW-1:0] word_l(input logic [AW-1:0] a);
        logic [31:0] h;
        if (a == 18'd100) return 16'h8000;
        if (a == 18'd101) return 16'h0004;
        if (a == 18'd102) return 16'h1234;
        h = 32'(a) * 32'd2654435761;
        return h[31:16];
    endfunction

    function automatic logic [DW-1:0] word_r(input logic [AW-1:0] a);
        logic [31:0] h;
        if (a == 18'd102) return 16'hABCD;
        h = (32'(a) ^ 32'h0001_5A5A) * 32'd40503;
        return h[23:8];
    endfunction

    // Synchronous ROMs: data appears one frame after address/rden.
    always @(posedge clk) begin
        if (m_rden) m_q <= word_l(m_addr);
        if (s_rden) s_q <= {word_l(s_addr), word_r(s_addr)};
    end

    // Attenuation as floor division by 2^sh; shifts of 16 and above give 0.
    function automatic logic [DW-1:0] exp_scale(input logic [DW-1:0] x, input int sh);
        int v;
        int p;
        if (sh >= DW) return 16'h0000;
        v = int'($signed(x));
        p = 1 << sh;
        if (v >= 0) return 16'(v / p);
        return 16'(-((-v + p - 1) / p));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_both(input string w, input bit ca, input logic [AW-1:0] ea,
                              input logic er, input logic ev,
                              input logic [DW-1:0] eml, input logic [DW-1:0] esl,
                              input logic [DW-1:0] esr, input logic eb, input logic ed);
        if (ca) begin
            chk({w, ":m_addr"}, 32'(m_addr), 32'(ea));
            chk({w, ":s_addr"}, 32'(s_addr), 32'(ea));
        end
        chk({w, ":m_rden"},  32'(m_rden), 32'(er));
        chk({w, ":s_rden"},  32'(s_rden), 32'(er));
        chk({w, ":m_valid"}, 32'(m_v),    32'(ev));
        chk({w, ":s_valid"}, 32'(s_v),    32'(ev));
        chk({w, ":m_l"},     32'(m_l),    32'(eml));
        chk({w, ":m_r"},     32'(m_r),    32'(eml));
        chk({w, ":s_l"},     32'(s_l),    32'(esl));
        chk({w, ":s_r"},     32'(s_r),    32'(esr));
        chk({w, ":m_busy"},  32'(m_busy), 32'(eb));
        chk({w, ":s_busy"},  32'(s_busy), 32'(eb));
        chk({w, ":m_done"},  32'(m_done), 32'(ed));
        chk({w, ":s_done"},  32'(s_done), 32'(ed));
    endtask

    // One play session. abort_k: frame at which play is seen low (-1 none).
    // rst_k: frame at which reset is asserted (-1 none). vfix: fixed volume or -1.
    task automatic do_run(input logic [AW-1:0] s, input logic [AW-1:0] e_in, input bit lp,
                          input int abort_k, input int rst_k, input int vfix, input bit gap);
        logic [AW-1:0] e;
        logic [AW-1:0] ea;
        logic [AW-1:0] sa;
        logic [4:0]    v;
        logic [DW-1:0] eml, esl, esr;
        int            n;
        int            last;
        bit            ev;
        e    = (e_in < s) ? s : e_in;
        n    = int'(e - s) + 1;
        last = (abort_k >= 0) ? abort_k : n + 1;
        for (int k = 0; k <= last; k++) begin
            play    = (abort_k >= 0 && k >= abort_k) ? 1'b0 : 1'b1;
            reset   = (k == rst_k) ? 1'b0 : 1'b1;
            loop_en = lp;
            if (k == 0) begin
                start_addr = s;
                end_addr   = e_in;
            end else begin
                start_addr = AW'($urandom);
                end_addr   = AW'($urandom);
            end
            v   = (vfix >= 0) ? 5'(vfix) : 5'($urandom_range(0, 31));
            vol = v;
            @(posedge clk);
            @(negedge clk);
            if (k == rst_k) begin
                check_both("reset_mid", 1'b1, {AW{1'b0}}, 1'b0, 1'b0, 16'h0000, 16'h0000,
                           16'h0000, 1'b0, 1'b0);
                reset = 1'b1;
                break;
            end
            if (abort_k >= 0 && k == abort_k) begin
                check_both("abort", 1'b0, {AW{1'b0}}, 1'b0, 1'b0, 16'h0000, 16'h0000,
                           16'h0000, 1'b0, 1'b0);
            end else begin
                if (lp) ea = AW'(int'(s) + (k % n));
                else    ea = (k < n) ? AW'(int'(s) + k) : e;
                ev = (k >= 2);
                if (ev) begin
                    sa  = AW'(int'(s) + ((k - 2) % n));
                    eml = exp_scale(word_l(sa), int'(v[3:0]));
                    esl = exp_scale(word_l(sa), int'(v));
                    esr = exp_scale(word_r(sa), int'(v));
                end else begin
                    eml = 16'h0000;
                    esl = 16'h0000;
                    esr = 16'h0000;
                end
                check_both("play", 1'b1, ea, (lp || k < n) ? 1'b1 : 1'b0, ev, eml, esl, esr,
                           1'b1, (!lp && k == n + 1) ? 1'b1 : 1'b0);
            end
        end
        if (gap) begin
            play       = 1'b0;
            start_addr = AW'($urandom);
            end_addr   = AW'($urandom);
            vol        = 5'($urandom_range(0, 31));
            @(posedge clk);
            @(negedge clk);
            check_both("idle", 1'b0, {AW{1'b0}}, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000,
                       1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [AW-1:0] rs, re;
        bit            rlp;
        int            rab, rn, d;
        reset      = 1'b0;
        play       = 1'b1;
        loop_en    = 1'b1;
        start_addr = 18'd7;
        end_addr   = 18'd9;
        vol        = 5'd0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_both("reset", 1'b1, {AW{1'b0}}, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000,
                       1'b0, 1'b0);
        end
        reset = 1'b1;

        // Directed sessions.
        do_run(18'd10, 18'd13, 1'b0, -1, -1, 0, 1'b1);       // one-shot
        do_run(18'd10, 18'd13, 1'b1, 9, -1, 0, 1'b0);        // loop, then stop
        do_run(18'd10, 18'd13, 1'b0, 3, -1, 0, 1'b1);        // stop at address 12
        do_run(18'd100, 18'd100, 1'b0, -1, -1, 2, 1'b0);     // 0x8000 >> 2, re-trigger
        do_run(18'd101, 18'd101, 1'b0, -1, -1, 15, 1'b0);    // 0x0004 >> 15
        do_run(18'd101, 18'd101, 1'b0, -1, -1, 16, 1'b1);    // shift 16 on stereo
        do_run(18'd102, 18'd102, 1'b1, 5, -1, 0, 1'b1);      // stereo halves
        do_run(18'd20, 18'd5, 1'b0, -1, -1, -1, 1'b1);       // inverted range
        do_run(18'd262141, 18'd262143, 1'b1, 8, -1, -1, 1'b0); // top of address space
        do_run(18'd55, 18'd55, 1'b1, 4, -1, -1, 1'b1);       // single-address loop
        do_run(18'd50, 18'd60, 1'b1, 20, 5, -1, 1'b0);       // reset mid-playback

        // Randomized sessions.
        for (int r = 0; r < 40; r++) begin
            rs = AW'($urandom_range(6, 262143));
            if ($urandom_range(0, 5) == 0) begin
                d  = $urandom_range(1, 5);
                re = AW'(int'(rs) - d);
            end else begin
                re = AW'(int'(rs) + $urandom_range(0, 5));
            end
            rn  = (re < rs) ? 1 : int'(re - rs) + 1;
            rlp = 1'($urandom_range(0, 1));
            if (rlp)                          rab = $urandom_range(1, 3 * rn + 2);
            else if ($urandom_range(0, 3) == 0) rab = $urandom_range(1, rn);
            else                              rab = -1;
            do_run(rs, re, rlp, rab, -1, -1, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_sample_sequencer.md
Name: audio_sample_sequencer

Overview:
- Parametrised playback engine that replaces the fixed free-running ROM address counter in the audio path.
- Clocked once per audio frame by DAC_LR_CLK.
- Plays a ROM region [start_addr..end_addr] in one-shot or loop mode under a play/stop handshake.
- Supports mono or interleaved stereo ROM words and applies per-frame attenuation.
- Feeds the serializer with left/right samples plus a valid flag.

Parameters:
- ADDR_W, 18, ROM address width.
- DATA_W, 16, signed sample width per channel.
- CHANNELS, 1, 1 = mono ROM word (L = R), 2 = stereo word {left[upper DATA_W], right[lower DATA_W]}.
- VOL_W, 4, width of attenuation shift input.

Ports:
- DAC_LR_CLK  in  1  frame clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low.
- play  in  1  level: 1 = run/keep running, 0 = stop.
- loop_en  in  1  1 = wrap at end_addr, 0 = one-shot.
- start_addr  in  ADDR_W  first address; latched at start.
- end_addr  in  ADDR_W  last address, inclusive; latched at start.
- vol_shift  in  VOL_W  arithmetic right-shift attenuation; sampled every frame.
- rom_addr  out  ADDR_W  ROM address.
- rom_rden  out  1  ROM read enable.
- rom_q  in  CHANNELS*DATA_W  ROM data; valid one frame after its address/rden.
- sample_l  out  DATA_W  left sample.
- sample_r  out  DATA_W  right sample.
- sample_valid  out  1  samples are live playback data.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-frame pulse on one-shot completion.

Behaviour:
- Reset is synchronous, active-low; clock is DAC_LR_CLK. Reset values: all outputs 0, state IDLE, latched start/end 0. Reset mid-playback aborts on the same edge.
- States: IDLE, PLAY, DRAIN.
- IDLE:
  - On play=1: latch start_addr/end_addr; if end < start, latch end = start.
  - rom_addr <= start, rom_rden <= 1, busy <= 1, go to PLAY.
- PLAY: each edge, sample_{l,r} <= scale(rom_q) for the previous address; sample_valid = 1 from the second PLAY edge onward.
  - Address advance: rom_addr+1 while rom_addr != end_lat.
  - At rom_addr == end_lat with loop_en=1: next rom_addr = start_lat, seamless, no gap frame.
  - At rom_addr == end_lat with loop_en=0: rom_rden <= 0, go to DRAIN.
  - play=0 (abort): next edge rom_rden=0, sample_valid=0, samples=0, busy=0, go to IDLE, no done pulse.
- DRAIN: output the last sample (valid=1) for one frame, pulse done=1, go to IDLE. Next edge: valid=0, busy=0, samples 0.
- Latency: first valid sample appears 2 edges after play is sampled high.
- Address wrap: rom_addr never exceeds end_lat. start==end with loop_en=1 repeats one address every frame.
- Re-trigger: play held high through done restarts from IDLE on the following edge (one idle frame).
- scale(x): signed arithmetic right shift by vol_shift. If vol_shift >= DATA_W, result is exactly 0 (not -1).
- Channel mapping: CHANNELS=1 gives sample_l = sample_r. CHANNELS=2 takes left from the upper half of rom_q.
- loop_en is sampled at the end_lat compare edge; changes mid-run take effect at the next end.

Optional Feature:
- Macro: AUDIO_SEQ_FADE_EN.
- Enabled:
  - 4-bit fade stage f adds an extra right shift of f, saturating total shift at DATA_W → 0.
  - On start, f = 8; it decrements by 1 per valid frame down to 0 (8-frame fade-in).
  - On play=0 in PLAY, playback continues while f increments by 1 per frame. When f reaches 8, behave as abort (IDLE, no done).
  - reset forces f = 0.
- Disabled: no fade logic, abrupt start/stop exactly as above.

Test Plan:
- reset=0 for 2 edges, then play=1, start=10, end=13, loop_en=0, rom_q=addr pattern → rom_addr 10,11,12,13; samples 10..13 valid on edges 2..5; done pulse on edge 5; busy low on edge 6.
- Same with loop_en=1 → rom_addr sequence 10,11,12,13,10,11 with no gap; sample_valid continuous; no done.
- play dropped during address 12 → next edge rom_rden=0, sample_valid=0, samples=0, busy=0, no done (FADE_EN off).
- vol_shift=2, rom_q=0x8000 → sample 0xE000. vol_shift=15, rom_q=0x0004 → 0. vol_shift=16 (VOL_W=5 build) → 0.
- CHANNELS=2, rom_q=0x1234_ABCD → sample_l=0x1234, sample_r=0xABCD. start=20, end=5 → plays only address 20, then done.
- AUDIO_SEQ_FADE_EN, rom_q=0x4000 constant, vol_shift=0 → first valid samples 0x0040,0x0080,…,0x4000. Stop ramps back down over 8 frames, then IDLE.
